// File: rtl/dut_parameters_pkg.sv
// Free-list sizing constants and the physical-register index type.
package dut_parameters_pkg;
  localparam int P_REGS = 64;
  localparam int L_REGS = 32;
  localparam int PREG_W = $clog2(P_REGS);

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PREG_W:0]   cnt_t;
endpackage

// File: rtl/dut_structs_pkg.sv
// Commit-slot packet carried from the ROB to the architectural register file.
package dut_structs_pkg;
  import dut_parameters_pkg::*;

  typedef struct packed {
    logic       valid_commit;
    logic       valid_write;
    logic [4:0] ldst;
    preg_t      pdst;
    preg_t      ppdst;
    logic       flushed;
  } writeback_toARF;
endpackage

// File: rtl/commit_free_list_if.sv
// Commit/allocate bundle between ROB, rename and the free list; slave is the free-list side.
interface commit_free_list_if;
  import dut_parameters_pkg::*;
  import dut_structs_pkg::*;

  writeback_toARF commit_1_i;
  writeback_toARF commit_2_i;
  logic           alloc_req_1_i;
  logic           alloc_req_2_i;
  preg_t          alloc_preg_1_o;
  preg_t          alloc_preg_2_o;
  logic           one_free_o;
  logic           two_free_o;
  cnt_t           free_count_o;
  logic           overflow_o;
  logic           dup_err_o;

  modport slave (
    input  commit_1_i, commit_2_i, alloc_req_1_i, alloc_req_2_i,
    output alloc_preg_1_o, alloc_preg_2_o, one_free_o, two_free_o,
           free_count_o, overflow_o, dup_err_o
  );

  modport master (
    output commit_1_i, commit_2_i, alloc_req_1_i, alloc_req_2_i,
    input  alloc_preg_1_o, alloc_preg_2_o, one_free_o, two_free_o,
           free_count_o, overflow_o, dup_err_o
  );
endinterface

// File: rtl/commit_free_list.sv
// Circular physical-register free list: 2 grants/cycle (0-cycle offer), 2 releases/cycle (usable next cycle).
// Over-count allocations are ignored, excess releases dropped (sticky overflow); FREELIST_DUP_CHECK_EN adds duplicate filtering.
module commit_free_list
  import dut_parameters_pkg::*;
  import dut_structs_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  commit_free_list_if.slave fl
);

  preg_t entry_q [P_REGS];
  preg_t head_q, head_d, tail_q, tail_d, wr_idx_2;
  cnt_t  count_q, count_d, base;
  logic  overflow_q, overflow_d;
  logic  [1:0] n_req, n_alloc;
  logic  alloc_ok;
  logic  rel_en_1, rel_en_2, cand_1, cand_2, acc_1, acc_2, dup_1, dup_2;
  preg_t rel_p_1, rel_p_2;

  always_comb begin
    n_req    = {1'b0, fl.alloc_req_1_i} + {1'b0, fl.alloc_req_2_i};
    alloc_ok = cnt_t'(n_req) <= count_q;
    n_alloc  = alloc_ok ? n_req : 2'd0;

    rel_en_1 = fl.commit_1_i.valid_commit && fl.commit_1_i.valid_write && (fl.commit_1_i.ldst != '0);
    rel_en_2 = fl.commit_2_i.valid_commit && fl.commit_2_i.valid_write && (fl.commit_2_i.ldst != '0);
    rel_p_1  = fl.commit_1_i.flushed ? fl.commit_1_i.pdst : fl.commit_1_i.ppdst;
    rel_p_2  = fl.commit_2_i.flushed ? fl.commit_2_i.pdst : fl.commit_2_i.ppdst;

    cand_1 = rel_en_1 && !dup_1;
    cand_2 = rel_en_2 && !dup_2;
    // Room is judged after this cycle's grants leave, so a full list can absorb releases as it drains.
    base   = count_q - cnt_t'(n_alloc);
    acc_1  = cand_1 && (base < cnt_t'(P_REGS));
    acc_2  = cand_2 && ((base + cnt_t'(acc_1)) < cnt_t'(P_REGS));

    overflow_d = overflow_q || (cand_1 && !acc_1) || (cand_2 && !acc_2);
    head_d     = head_q + preg_t'(n_alloc);
    wr_idx_2   = tail_q + preg_t'(acc_1);
    tail_d     = wr_idx_2 + preg_t'(acc_2);
    count_d    = base + cnt_t'(acc_1) + cnt_t'(acc_2);
  end

  assign fl.alloc_preg_1_o = entry_q[head_q];
  assign fl.alloc_preg_2_o = entry_q[head_q + preg_t'(fl.alloc_req_1_i)];
  assign fl.one_free_o     = count_q != '0;
  assign fl.two_free_o     = count_q >= cnt_t'(2);
  assign fl.free_count_o   = count_q;
  assign fl.overflow_o     = overflow_q;

`ifdef FREELIST_DUP_CHECK_EN
  logic [P_REGS-1:0] is_free_q, is_free_d;
  logic              dup_err_q, dup_err_d;

  always_comb begin
    dup_1     = rel_en_1 && is_free_q[rel_p_1];
    dup_2     = rel_en_2 && (is_free_q[rel_p_2] || (rel_en_1 && (rel_p_2 == rel_p_1)));
    dup_err_d = dup_err_q || dup_1 || dup_2;
    is_free_d = is_free_q;
    if (alloc_ok && fl.alloc_req_1_i) is_free_d[fl.alloc_preg_1_o] = 1'b0;
    if (alloc_ok && fl.alloc_req_2_i) is_free_d[fl.alloc_preg_2_o] = 1'b0;
    if (acc_1) is_free_d[rel_p_1] = 1'b1;
    if (acc_2) is_free_d[rel_p_2] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_free_q <= {{(P_REGS-L_REGS){1'b1}}, {L_REGS{1'b0}}};
      dup_err_q <= 1'b0;
    end else begin
      is_free_q <= is_free_d;
      dup_err_q <= dup_err_d;
    end
  end

  assign fl.dup_err_o = dup_err_q;
`else
  assign dup_1        = 1'b0;
  assign dup_2        = 1'b0;
  assign fl.dup_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < P_REGS; i++) begin
        entry_q[i] <= (i < P_REGS - L_REGS) ? preg_t'(L_REGS + i) : '0;
      end
      head_q     <= '0;
      tail_q     <= preg_t'(P_REGS - L_REGS);
      count_q    <= cnt_t'(P_REGS - L_REGS);
      overflow_q <= 1'b0;
    end else begin
      if (acc_1) entry_q[tail_q]   <= rel_p_1;
      if (acc_2) entry_q[wr_idx_2] <= rel_p_2;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_commit_free_list.sv
// Scoreboard bench for commit_free_list: a queue model of the free FIFO predicts every grant and status output.
module tb_commit_free_list;
  import dut_parameters_pkg::*;
  import dut_structs_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  commit_free_list_if fl();
  commit_free_list dut (.clk(clk), .rst_n(rst_n), .fl(fl));

  int checks = 0;
  int failures = 0;
  int free_q[$];
  int held[$];
  bit [63:0] exp_free;
  bit exp_ovf, exp_dup;
  int last_grant;
  writeback_toARF z;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic writeback_toARF mk(input bit vc, input bit vw, input int ldst,
                                        input int pdst, input int ppdst, input bit fls);
    writeback_toARF c;
    c.valid_commit = vc;
    c.valid_write  = vw;
    c.ldst         = 5'(ldst);
    c.pdst         = preg_t'(pdst);
    c.ppdst        = preg_t'(ppdst);
    c.flushed      = fls;
    return c;
  endfunction

  task automatic model_reset();
    free_q.delete();
    held.delete();
    for (int i = 0; i < 32; i++) free_q.push_back(32 + i);
    for (int i = 0; i < 32; i++) held.push_back(i);
    exp_free = {32'hFFFF_FFFF, 32'h0};
    exp_ovf  = 1'b0;
    exp_dup  = 1'b0;
  endtask

  task automatic model_release(input writeback_toARF c, input bit other_en, input int other_p,
                               output bit en, output int p);
    bit drop_dup;
    en = c.valid_commit && c.valid_write && (c.ldst != 0);
    p  = c.flushed ? int'(c.pdst) : int'(c.ppdst);
    drop_dup = 1'b0;
`ifdef FREELIST_DUP_CHECK_EN
    if (en && (exp_free[p] || (other_en && other_p == p))) begin
      drop_dup = 1'b1;
      exp_dup  = 1'b1;
    end
`endif
    if (en && !drop_dup) begin
      if (free_q.size() >= 64) exp_ovf = 1'b1;
      else begin
        free_q.push_back(p);
        exp_free[p] = 1'b1;
      end
    end
  endtask

  task automatic check_status();
    check_eq("count", int'(fl.free_count_o), free_q.size());
    check_eq("one_free", int'(fl.one_free_o), int'(free_q.size() >= 1));
    check_eq("two_free", int'(fl.two_free_o), int'(free_q.size() >= 2));
    check_eq("overflow", int'(fl.overflow_o), int'(exp_ovf));
    check_eq("dup_err", int'(fl.dup_err_o), int'(exp_dup));
    if (free_q.size() >= 1) check_eq("offer1", int'(fl.alloc_preg_1_o), free_q[0]);
  endtask

  task automatic drive(input logic r1, input logic r2, input writeback_toARF c1, input writeback_toARF c2);
    int n, p1, p2, g;
    bit en1, en2;
    @(negedge clk);
    fl.alloc_req_1_i = r1;
    fl.alloc_req_2_i = r2;
    fl.commit_1_i    = c1;
    fl.commit_2_i    = c2;
    #1;
    check_status();
    n = int'(r1) + int'(r2);
    if (n <= free_q.size()) begin
      if (r1) check_eq("grant1", int'(fl.alloc_preg_1_o), free_q[0]);
      if (r2) check_eq("grant2", int'(fl.alloc_preg_2_o), free_q[r1 ? 1 : 0]);
      repeat (n) begin
        g = free_q.pop_front();
        exp_free[g] = 1'b0;
        held.push_back(g);
        last_grant = g;
      end
    end
    model_release(c1, 1'b0, 0, en1, p1);
    model_release(c2, en1, p1, en2, p2);
    @(posedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, z, z);
  endtask

  function automatic writeback_toARF rand_rel();
    writeback_toARF c;
    int idx, p;
    if (held.size() > 0 && $urandom_range(0, 3) != 0) begin
      idx = $urandom_range(0, held.size() - 1);
      p   = held[idx];
      held.delete(idx);
      if ($urandom_range(0, 1) == 1) c = mk(1, 1, $urandom_range(1, 31), p, $urandom_range(0, 63), 1);
      else                           c = mk(1, 1, $urandom_range(1, 31), $urandom_range(0, 63), p, 0);
    end else if ($urandom_range(0, 1) == 1) begin
      c = mk(1, 1, 0, $urandom_range(0, 63), $urandom_range(0, 63), 0);
    end else begin
      c = mk(1, 0, $urandom_range(1, 31), $urandom_range(0, 63), $urandom_range(0, 63), 0);
    end
    return c;
  endfunction

  initial begin
    z = mk(0, 0, 0, 0, 0, 0);
    fl.alloc_req_1_i = 1'b0;
    fl.alloc_req_2_i = 1'b0;
    fl.commit_1_i    = z;
    fl.commit_2_i    = z;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state, then a dual grant and a slot-2-only grant.
    idle();
    drive(1, 1, z, z);
    idle();
    drive(0, 1, z, z);
    check_eq("slot2_only_grant", last_grant, 34);

    // Retired op returns ppdst; it surfaces only after the older free entries drain.
    drive(0, 0, mk(1, 1, 3, 40, 5, 0), z);
    while (free_q.size() > 0) drive(1, free_q.size() >= 2, z, z);
    check_eq("retire_ppdst_last", last_grant, 5);

    // Squashed op returns pdst; disabled slots change nothing.
    drive(0, 0, z, mk(1, 1, 4, 40, 9, 1));
    drive(0, 0, mk(1, 1, 0, 11, 12, 0), mk(1, 0, 6, 13, 14, 0));
    drive(1, 0, z, z);
    check_eq("flush_pdst", last_grant, 40);

    // Empty list with same-cycle release: request ignored, preg usable next cycle.
    drive(1, 0, mk(1, 1, 2, 20, 7, 0), z);
    drive(1, 0, z, z);
    check_eq("no_bypass_grant", last_grant, 7);
    idle();

    // Fill to P_REGS, then push one more.
    for (int i = 0; i < 32; i++) drive(0, 0, mk(1, 1, 1, 0, 2 * i, 0), mk(1, 1, 1, 0, 2 * i + 1, 0));
    drive(0, 0, mk(1, 1, 1, 0, 10, 0), z);
    idle();
    idle();
    drive(0, 0, z, mk(1, 1, 8, 50, 0, 1));
    idle();

    // Reset mid-operation discards the same-cycle request and release.
    @(negedge clk);
    rst_n = 1'b0;
    fl.alloc_req_1_i = 1'b1;
    fl.commit_1_i    = mk(1, 1, 3, 0, 5, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fl.alloc_req_1_i = 1'b0;
    fl.commit_1_i    = z;
    model_reset();
    idle();

    for (int i = 0; i < 400; i++) begin
      logic r1, r2;
      writeback_toARF c1, c2;
      r1 = (free_q.size() >= 1) && ($urandom_range(0, 1) == 1);
      r2 = (free_q.size() >= (r1 ? 2 : 1)) && ($urandom_range(0, 1) == 1);
      c1 = rand_rel();
      c2 = rand_rel();
      drive(r1, r2, c1, c2);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
